// File: rtl/tpu_stream_loader.sv
// Host-side sequencer for tt_um_tpu: collects one job from a byte stream, bursts it into the TPU,
// captures the result bytes and streams them back. Optional done watchdog: TPU_LOADER_TIMEOUT_EN.
module tpu_stream_loader #(
    parameter int N_LOAD   = 8,
    parameter int N_RESULT = 4
`ifdef TPU_LOADER_TIMEOUT_EN
    ,
    parameter int TMO_W    = 8
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic [1:0] s_cfg,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic [7:0] tpu_data,
    output logic [2:0] tpu_ctrl,
    input  logic [7:0] tpu_result,
    input  logic       tpu_done,
    output logic       busy,
    output logic       err
);

    localparam int LD_W  = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;
    localparam int RES_W = (N_RESULT > 1) ? $clog2(N_RESULT) : 1;
    localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(N_LOAD - 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(N_RESULT - 1);

    // Both streams use plain valid/ready: a byte moves on a rising edge where valid and ready are
    // both high; the sender holds data stable while valid is high and ready is low.

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_BURST,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [LD_W-1:0]  cnt_q, cnt_d;
    logic [RES_W-1:0] idx_q, idx_d;
    logic [1:0]       cfg_q, cfg_d;
    logic [7:0]       ld_buf_q [N_LOAD];
    logic [7:0]       ld_buf_d [N_LOAD];
    logic [7:0]       res_q [N_RESULT];
    logic [7:0]       res_d [N_RESULT];

    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic [7:0]       tpu_data_q, tpu_data_d;
    logic [2:0]       tpu_ctrl_q, tpu_ctrl_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

`ifdef TPU_LOADER_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        cfg_d    = cfg_q;
        ld_buf_d = ld_buf_q;
        res_d    = res_q;
        err_d    = err_q;
`ifdef TPU_LOADER_TIMEOUT_EN
        tmo_d    = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (s_valid && s_ready_q) begin
                    ld_buf_d[0] = s_data;
                    cfg_d       = s_cfg;
                    cnt_d       = LD_W'(1);
                    state_d     = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (s_valid && s_ready_q) begin
                    ld_buf_d[cnt_q] = s_data;
                    if (cnt_q == LD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_BURST;
                    end else begin
                        cnt_d = cnt_q + LD_W'(1);
                    end
                end
            end
            S_BURST: begin
                if (cnt_q == LD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + LD_W'(1);
                end
            end
            S_WAIT: begin
                // A done level already present on entry counts; no edge detection.
                if (tpu_done) begin
                    res_d[0] = tpu_result;
                    idx_d    = RES_W'(1);
                    state_d  = S_CAPTURE;
                end
`ifdef TPU_LOADER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d = 1'b1;
                    for (int i = 0; i < N_RESULT; i++) begin
                        res_d[i] = 8'hFF;
                    end
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            S_CAPTURE: begin
                res_d[idx_q] = tpu_result;
                if (idx_q == RES_LAST) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + RES_W'(1);
                end
            end
            S_DRAIN: begin
                if (m_valid_q && m_ready) begin
                    if (idx_q == RES_LAST) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + RES_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state so they are registered yet cycle-aligned.
        s_ready_d  = (state_d == S_IDLE) || (state_d == S_COLLECT);
        busy_d     = (state_d != S_IDLE);
        tpu_data_d = '0;
        tpu_ctrl_d = '0;
        case (state_d)
            S_BURST: begin
                tpu_data_d = ld_buf_d[cnt_d];
                tpu_ctrl_d = {cfg_d, 1'b1};
            end
            S_WAIT, S_CAPTURE: tpu_ctrl_d = {cfg_d, 1'b0};
            default: ;
        endcase
        m_valid_d = (state_d == S_DRAIN);
        m_data_d  = m_valid_d ? res_d[idx_d] : 8'h00;
        m_last_d  = m_valid_d && (idx_d == RES_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            cfg_q      <= '0;
            for (int i = 0; i < N_LOAD; i++) begin
                ld_buf_q[i] <= '0;
            end
            for (int i = 0; i < N_RESULT; i++) begin
                res_q[i] <= '0;
            end
            s_ready_q  <= 1'b1;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            tpu_data_q <= '0;
            tpu_ctrl_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef TPU_LOADER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cfg_q      <= cfg_d;
            ld_buf_q   <= ld_buf_d;
            res_q      <= res_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            tpu_data_q <= tpu_data_d;
            tpu_ctrl_q <= tpu_ctrl_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef TPU_LOADER_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign tpu_data = tpu_data_q;
    assign tpu_ctrl = tpu_ctrl_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_tpu_stream_loader.sv
// Self-checking bench for tpu_stream_loader: table-driven jobs against a small TPU model,
// plus hand-written reset-mid-burst and (with TPU_LOADER_TIMEOUT_EN) watchdog sequences.
module tb_tpu_stream_loader;

    localparam int DONE_DLY = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [1:0] s_cfg;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [7:0] tpu_data;
    logic [2:0] tpu_ctrl;
    logic [7:0] tpu_result;
    logic       tpu_done;
    logic       busy;
    logic       err;

`ifdef TPU_LOADER_TIMEOUT_EN
    tpu_stream_loader #(.N_LOAD(8), .N_RESULT(4), .TMO_W(4)) dut (
`else
    tpu_stream_loader #(.N_LOAD(8), .N_RESULT(4)) dut (
`endif
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_cfg(s_cfg),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .tpu_data(tpu_data), .tpu_ctrl(tpu_ctrl), .tpu_result(tpu_result), .tpu_done(tpu_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // TPU model: done pulses in the DONE_DLY-th cycle after load_en drops, with result bytes
    // c00..c11 on that cycle and the following three.
    int          tm_phase;
    bit          tm_en;
    logic [31:0] tm_res;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_phase   <= -1;
            tpu_done   <= 1'b0;
            tpu_result <= 8'h00;
        end else if (tpu_ctrl[0]) begin
            tm_phase   <= 0;
            tpu_done   <= 1'b0;
            tpu_result <= 8'h00;
        end else if (tm_phase >= 0) begin
            tm_phase   <= (tm_phase + 1 >= DONE_DLY + 4) ? -1 : tm_phase + 1;
            tpu_done   <= tm_en && (tm_phase + 1 == DONE_DLY);
            tpu_result <= (tm_en && tm_phase + 1 >= DONE_DLY && tm_phase + 1 < DONE_DLY + 4)
                          ? tm_res[8*(tm_phase+1-DONE_DLY) +: 8] : 8'h00;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  cfg0;      // s_cfg with byte 0
        logic [1:0]  cfg_rest;  // s_cfg with bytes 1..7 (must be ignored)
        logic [63:0] ld;        // byte k in ld[8k +: 8]
        bit          stall_in;  // idle cycle before each of bytes 1..7
        int          bp_idx;    // result byte held off by m_ready=0 (-1: none)
        int          bp_len;
        logic [31:0] exp_res;   // c00 in [7:0]
        int          exp_wait;  // cycles from end of burst to first m_valid
        bit          exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic send_byte(input logic [7:0] d, input logic [1:0] cfg, input bit bubble);
        int t;
        @(negedge clk);
        if (bubble) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_cfg   = cfg;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("s_ready_collect", s_ready, 1);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int waited;
        int hold;
        tm_res = v.exp_res;
        for (int k = 0; k < 8; k++) begin
            send_byte(v.ld[8*k +: 8], (k == 0) ? v.cfg0 : v.cfg_rest, v.stall_in && k > 0);
        end
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s burst_ctrl[%0d]", tag, k), tpu_ctrl, {v.cfg0, 1'b1});
            check($sformatf("%s burst_data[%0d]", tag, k), tpu_data, v.ld[8*k +: 8]);
            check($sformatf("%s burst_s_ready[%0d]", tag, k), s_ready, 0);
            @(negedge clk);
        end
        waited = 0;
        while (!m_valid && waited < 200) begin
            check($sformatf("%s wait_ctrl[%0d]", tag, waited), tpu_ctrl, {v.cfg0, 1'b0});
            check($sformatf("%s wait_s_ready[%0d]", tag, waited), s_ready, 0);
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s latency", tag), waited, v.exp_wait);
        check($sformatf("%s err_drain", tag), err, v.exp_err);
        for (int j = 0; j < 4; j++) begin
            hold = (j == v.bp_idx) ? v.bp_len : 0;
            for (int s = 0; s < hold; s++) begin
                m_ready = 1'b0;
                check($sformatf("%s hold_valid[%0d]", tag, j), m_valid, 1);
                check($sformatf("%s hold_data[%0d]", tag, j), m_data, v.exp_res[8*j +: 8]);
                check($sformatf("%s hold_s_ready[%0d]", tag, j), s_ready, 0);
                @(negedge clk);
            end
            m_ready = 1'b1;
            check($sformatf("%s m_valid[%0d]", tag, j), m_valid, 1);
            check($sformatf("%s m_data[%0d]", tag, j), m_data, v.exp_res[8*j +: 8]);
            check($sformatf("%s m_last[%0d]", tag, j), m_last, (j == 3) ? 1 : 0);
            check($sformatf("%s drain_s_ready[%0d]", tag, j), s_ready, 0);
            @(negedge clk);
        end
        m_ready = 1'b0;
        check($sformatf("%s end_m_valid", tag), m_valid, 0);
        check($sformatf("%s end_s_ready", tag), s_ready, 1);
        check($sformatf("%s end_busy", tag), busy, 0);
        check($sformatf("%s end_err", tag), err, v.exp_err);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " s_ready"}, s_ready, 1);
        check({tag, " m_valid"}, m_valid, 0);
        check({tag, " m_last"}, m_last, 0);
        check({tag, " m_data"}, m_data, 0);
        check({tag, " tpu_data"}, tpu_data, 0);
        check({tag, " tpu_ctrl"}, tpu_ctrl, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " err"}, err, 0);
    endtask

    initial begin
        // Done is raised in the 3rd WAIT cycle, then 3 CAPTURE cycles: 6 cycles to first m_valid.
        vecs[0] = '{2'b00, 2'b00, 64'h0807060504030201, 1'b0, -1, 0, 32'h44332211, 6, 1'b0};
        vecs[1] = '{2'b01, 2'b01, 64'hA7A6A5A4A3A2A1A0, 1'b1, -1, 0, 32'h88776655, 6, 1'b0};
        vecs[2] = '{2'b10, 2'b10, 64'h1716151413121110, 1'b0, 2, 5, 32'h44332211, 6, 1'b0};
        vecs[3] = '{2'b11, 2'b00, 64'h7F80FF00C3A55A3C, 1'b1, 3, 2, 32'h04030201, 6, 1'b0};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_cfg   = 2'b00;
        m_ready = 1'b0;
        tm_en   = 1'b1;
        tm_res  = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset pulse while load byte 4 is on tpu_data.
        tm_res = vecs[0].exp_res;
        for (int k = 0; k < 8; k++) begin
            send_byte(vecs[0].ld[8*k +: 8], 2'b11, 1'b0);
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst load_en", tpu_ctrl, 3'b111);
        check("midrst byte4", tpu_data, 8'h05);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst no_output", m_valid, 0);
        check("midrst idle", busy, 0);
        run_job(vecs[0], "after_rst");

`ifdef TPU_LOADER_TIMEOUT_EN
        // Done never comes: 15 WAIT cycles, then four FF bytes and a sticky err.
        tm_en = 1'b0;
        run_job('{2'b01, 2'b01, 64'h0102030405060708, 1'b0, 1, 3, 32'hFFFFFFFF, 15, 1'b1},
                "timeout");
        repeat (3) @(negedge clk);
        check("timeout err_sticky", err, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("timeout err_cleared", err, 0);
        tm_en = 1'b1;
        run_job(vecs[1], "post_tmo");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
